// File: rtl/upgrade_spawner_pkg.sv
// Shared game package.
// Holds the upgrade spawner state encoding, the playfield bounds used by the
// ball and upgrade modules, the LFSR tap mask, and a small distance helper.
package upgrade_spawner_pkg;

    // Playfield bounds for object centres (inclusive), shared with the ball logic.
    localparam int unsigned PLAYFIELD_X_MIN = 40;
    localparam int unsigned PLAYFIELD_X_MAX = 600;
    localparam int unsigned PLAYFIELD_Y_MIN = 40;
    localparam int unsigned PLAYFIELD_Y_MAX = 440;

    // 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.
    // Feedback is the XOR of bits 9 and 6; the result shifts in at bit 0.
    localparam int unsigned LFSR_W    = 10;
    localparam logic [9:0]  LFSR_TAPS = 10'h240;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_PICK_X = 3'd1,
        S_PICK_Y = 3'd2,
        S_CHECK  = 3'd3,
        S_SPAWN  = 3'd4,
        S_ACTIVE = 3'd5
    } spawner_state_t;

    // |a - b| widened to 11 bits so it can be compared against an 11-bit reach
    // value without any wrap.
    function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] diff;
        if (a >= b) begin
            diff = {1'b0, a - b};
        end else begin
            diff = {1'b0, b - a};
        end
        return diff;
    endfunction

endpackage

// File: rtl/upgrade_spawner_lfsr10.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1), generic random source.
// Ports:
//   clk   - clock
//   srst  - synchronous active-high reset, loads SEED (0 is replaced by 1)
//   step  - advance one position when high
//   value - current LFSR contents, never zero
module lfsr10
    import upgrade_spawner_pkg::*;
#(
    parameter logic [9:0] SEED = 10'h1A5
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       step,
    output logic [9:0] value
);

    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [9:0] SEED_SAFE = (SEED == 10'd0) ? 10'd1 : SEED;

    logic [9:0] value_reg;
    logic       feedback;

    assign feedback = ^(value_reg & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (srst) begin
            value_reg <= SEED_SAFE;
        end else if (step) begin
            value_reg <= {value_reg[8:0], feedback};
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/upgrade_spawner.sv
// Upgrade spawner: producer end of the upgrade pickup interface.
// Places one upgrade on the playfield, waits for a collector to pick it up,
// hides it for a cooldown, then respawns it at a random position that keeps
// clear of both players. Runs once per frame on frame_clk.
// Ports:
//   frame_clk            - frame clock
//   Reset                - synchronous active-high reset
//   enable               - game running; freezes the wait counter when low
//   collected            - pickup level from the collectors (used in ACTIVE only)
//   BallX/BallY          - player 1 centre
//   Ball2X/Ball2Y        - player 2 centre
//   Ball_Size            - ball half-size
//   UpgradeX/UpgradeY    - upgrade centre (held after pickup)
//   Upgrade_Size         - constant upgrade half-size
//   upgrade_valid        - upgrade visible and collectable
//   respawn              - one-cycle pulse on each spawn
//   spawn_count          - spawns since reset, saturating at 255
module upgrade_spawner
    import upgrade_spawner_pkg::*;
#(
    parameter int unsigned COOLDOWN_FRAMES = 300,
    parameter int unsigned INITIAL_DELAY   = 60,
    parameter int unsigned UPGRADE_SIZE    = 8,
    parameter int unsigned X_MIN           = PLAYFIELD_X_MIN,
    parameter int unsigned X_MAX           = PLAYFIELD_X_MAX,
    parameter int unsigned Y_MIN           = PLAYFIELD_Y_MIN,
    parameter int unsigned Y_MAX           = PLAYFIELD_Y_MAX,
    parameter int unsigned CLEARANCE       = 16,
    parameter logic [9:0]  LFSR_SEED       = 10'h1A5,
    parameter int unsigned MAX_TRIES       = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       collected,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] Ball2X,
    input  logic [9:0] Ball2Y,
    input  logic [9:0] Ball_Size,
    output logic [9:0] UpgradeX,
    output logic [9:0] UpgradeY,
    output logic [9:0] Upgrade_Size,
    output logic       upgrade_valid,
    output logic       respawn,
    output logic [7:0] spawn_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [9:0]       X_MIN_V    = 10'(X_MIN);
    localparam logic [9:0]       X_MAX_V    = 10'(X_MAX);
    localparam logic [9:0]       Y_MIN_V    = 10'(Y_MIN);
    localparam logic [9:0]       Y_MAX_V    = 10'(Y_MAX);
    localparam logic [9:0]       FALLBACK_X = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0]       FALLBACK_Y = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic [10:0]      REACH_BASE = 11'(UPGRADE_SIZE + CLEARANCE);
    localparam logic [CNT_W-1:0] COOLDOWN_V = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] INITIAL_V  = CNT_W'(INITIAL_DELAY);
    localparam logic [TRY_W-1:0] TRIES_MAX  = TRY_W'(MAX_TRIES);

    spawner_state_t   state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [TRY_W-1:0] tries_reg;
    logic [TRY_W-1:0] tries_next;
    logic [9:0]       cand_x_reg;
    logic [9:0]       cand_y_reg;
    logic             cand_bad_reg;   // candidate already failed the range test
    logic [9:0]       upgrade_x_reg;
    logic [9:0]       upgrade_y_reg;
    logic             upgrade_valid_reg;
    logic             respawn_reg;
    logic [7:0]       spawn_count_reg;

    logic [9:0]       lfsr_value;
    logic             x_in_range;
    logic             y_in_range;
    logic [10:0]      reach;
    logic [9:0]       ball_x [2];
    logic [9:0]       ball_y [2];
    logic [1:0]       ball_hit;
    logic             reject;

    // The random source runs every non-reset cycle, independent of enable,
    // so a paused game still changes where the next upgrade lands.
    lfsr10 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (frame_clk),
        .srst  (Reset),
        .step  (1'b1),
        .value (lfsr_value)
    );

    assign x_in_range = (lfsr_value >= X_MIN_V) && (lfsr_value <= X_MAX_V);
    assign y_in_range = (lfsr_value >= Y_MIN_V) && (lfsr_value <= Y_MAX_V);

    // Overlap box half-width per ball; 11 bits so Ball_Size near 1023 cannot wrap.
    assign reach = {1'b0, Ball_Size} + REACH_BASE;

    assign ball_x[0] = BallX;
    assign ball_y[0] = BallY;
    assign ball_x[1] = Ball2X;
    assign ball_y[1] = Ball2Y;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ball
            logic [10:0] dx;
            logic [10:0] dy;
            assign dx           = abs_diff11(cand_x_reg, ball_x[gi]);
            assign dy           = abs_diff11(cand_y_reg, ball_y[gi]);
            assign ball_hit[gi] = (dx <= reach) && (dy <= reach);
        end
    endgenerate

    assign reject     = cand_bad_reg || (|ball_hit);
    assign tries_next = tries_reg + 1'b1;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg         <= S_WAIT;
            wait_cnt_reg      <= INITIAL_V;
            tries_reg         <= '0;
            cand_x_reg        <= '0;
            cand_y_reg        <= '0;
            cand_bad_reg      <= 1'b0;
            upgrade_x_reg     <= '0;
            upgrade_y_reg     <= '0;
            upgrade_valid_reg <= 1'b0;
            respawn_reg       <= 1'b0;
            spawn_count_reg   <= '0;
        end else begin
            respawn_reg <= 1'b0;
            case (state_reg)
                S_WAIT: begin
                    if (enable) begin
                        if (wait_cnt_reg == '0) begin
                            state_reg <= S_PICK_X;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 1'b1;
                        end
                    end
                end

                S_PICK_X: begin
                    cand_x_reg   <= lfsr_value;
                    cand_bad_reg <= !x_in_range;
                    state_reg    <= S_PICK_Y;
                end

                // Y takes the LFSR value one step after X.
                S_PICK_Y: begin
                    cand_y_reg   <= lfsr_value;
                    cand_bad_reg <= cand_bad_reg || !y_in_range;
                    state_reg    <= S_CHECK;
                end

                // Outputs are registered on the way into SPAWN so that
                // respawn, upgrade_valid and the new position appear together.
                S_CHECK: begin
                    if (!reject || (tries_next == TRIES_MAX)) begin
                        upgrade_x_reg     <= reject ? FALLBACK_X : cand_x_reg;
                        upgrade_y_reg     <= reject ? FALLBACK_Y : cand_y_reg;
                        upgrade_valid_reg <= 1'b1;
                        respawn_reg       <= 1'b1;
                        if (spawn_count_reg != 8'hFF) begin
                            spawn_count_reg <= spawn_count_reg + 1'b1;
                        end
                        state_reg <= S_SPAWN;
                    end else begin
                        state_reg <= S_PICK_X;
                    end
                    if (reject) begin
                        tries_reg <= tries_next;
                    end
                end

                S_SPAWN: begin
                    tries_reg <= '0;
                    state_reg <= S_ACTIVE;
                end

                S_ACTIVE: begin
                    if (collected) begin
                        upgrade_valid_reg <= 1'b0;
                        wait_cnt_reg      <= COOLDOWN_V;
                        state_reg         <= S_WAIT;
                    end
                end

                default: begin
                    state_reg <= S_WAIT;
                end
            endcase
        end
    end

    assign UpgradeX      = upgrade_x_reg;
    assign UpgradeY      = upgrade_y_reg;
    assign Upgrade_Size  = 10'(UPGRADE_SIZE);
    assign upgrade_valid = upgrade_valid_reg;
    assign respawn       = respawn_reg;
    assign spawn_count   = spawn_count_reg;

endmodule

// File: tb/tb_upgrade_spawner.sv
// Self-checking bench for upgrade_spawner.
// Two instances: dut_main uses the default timing; dut_fast has no cooldown and
// a short initial delay, used for the long saturation run. Only one instance
// is out of reset at a time; sel picks whose outputs are observed.
// The reference model predicts each spawn from the placement rules: it walks
// the candidate pairs taken from the LFSR sequence (indexed by cycles since
// reset), applies the range and clearance rules with integer arithmetic and
// falls back to the playfield centre after the allowed number of rejections.
module tb_upgrade_spawner;

    localparam int SEED      = 'h1A5;
    localparam int UPG_SIZE  = 8;
    localparam int CLEAR     = 16;
    localparam int XMIN      = 40;
    localparam int XMAX      = 600;
    localparam int YMIN      = 40;
    localparam int YMAX      = 440;
    localparam int TRIES     = 8;
    localparam int LF_PERIOD = 1023;

    logic       frame_clk = 1'b0;
    logic       rst_main  = 1'b1;
    logic       rst_fast  = 1'b1;
    logic       enable    = 1'b1;
    logic       collected = 1'b0;
    logic [9:0] b1x = 10'd100, b1y = 10'd100;
    logic [9:0] b2x = 10'd500, b2y = 10'd400;
    logic [9:0] bsize = 10'd10;
    bit         sel = 1'b0;

    logic [9:0] x_m, y_m, sz_m, x_f, y_f, sz_f;
    logic       v_m, r_m, v_f, r_f;
    logic [7:0] c_m, c_f;

    logic [9:0] obs_x, obs_y, obs_size;
    logic       obs_valid, obs_respawn;
    logic [7:0] obs_count;

    always #5 frame_clk = ~frame_clk;

    upgrade_spawner dut_main (
        .frame_clk     (frame_clk),
        .Reset         (rst_main),
        .enable        (enable),
        .collected     (collected),
        .BallX         (b1x),
        .BallY         (b1y),
        .Ball2X        (b2x),
        .Ball2Y        (b2y),
        .Ball_Size     (bsize),
        .UpgradeX      (x_m),
        .UpgradeY      (y_m),
        .Upgrade_Size  (sz_m),
        .upgrade_valid (v_m),
        .respawn       (r_m),
        .spawn_count   (c_m)
    );

    upgrade_spawner #(
        .COOLDOWN_FRAMES (0),
        .INITIAL_DELAY   (3)
    ) dut_fast (
        .frame_clk     (frame_clk),
        .Reset         (rst_fast),
        .enable        (enable),
        .collected     (collected),
        .BallX         (b1x),
        .BallY         (b1y),
        .Ball2X        (b2x),
        .Ball2Y        (b2y),
        .Ball_Size     (bsize),
        .UpgradeX      (x_f),
        .UpgradeY      (y_f),
        .Upgrade_Size  (sz_f),
        .upgrade_valid (v_f),
        .respawn       (r_f),
        .spawn_count   (c_f)
    );

    always_comb begin
        obs_x       = sel ? x_f  : x_m;
        obs_y       = sel ? y_f  : y_m;
        obs_size    = sel ? sz_f : sz_m;
        obs_valid   = sel ? v_f  : v_m;
        obs_respawn = sel ? r_f  : r_m;
        obs_count   = sel ? c_f  : c_m;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int ep       = 0;   // cycles since the last reset of the observed instance
    int pulse_cnt   = 0;
    int exp_pulses  = 0;
    int exp_count   = 0;
    int cfg_cool    = 300;
    int cfg_init    = 60;
    int lf_tab [LF_PERIOD];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // LFSR state after c steps from the seed.
    function automatic int lf(input int c);
        return lf_tab[c % LF_PERIOD];
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit too_close(input int cx, input int cy, input int bx, input int by);
        int reach;
        reach = int'(bsize) + UPG_SIZE + CLEAR;
        return (absd(cx, bx) <= reach) && (absd(cy, by) <= reach);
    endfunction

    // Placement starting with the first X pick at cycle p.
    task automatic model_spawn(input int p, output int s, output int xe, output int ye);
        int cx, cy;
        bit ok;
        s  = p + 3 * TRIES;
        xe = (XMIN + XMAX) / 2;
        ye = (YMIN + YMAX) / 2;
        for (int t = 0; t < TRIES; t++) begin
            cx = lf(p + 3 * t);
            cy = lf(p + 3 * t + 1);
            ok = (cx >= XMIN) && (cx <= XMAX) && (cy >= YMIN) && (cy <= YMAX) &&
                 !too_close(cx, cy, int'(b1x), int'(b1y)) &&
                 !too_close(cx, cy, int'(b2x), int'(b2y));
            if (ok) begin
                s  = p + 3 * t + 3;
                xe = cx;
                ye = cy;
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
        ep++;
        if (obs_respawn) pulse_cnt++;
    endtask

    task automatic apply_reset();
        if (sel) rst_fast = 1'b1; else rst_main = 1'b1;
        tick();
        if (sel) rst_fast = 1'b0; else rst_main = 1'b0;
        ep         = 0;
        pulse_cnt  = 0;
        exp_pulses = 0;
        exp_count  = 0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_x"},       obs_x, 0);
        check_eq({tag, "_y"},       obs_y, 0);
        check_eq({tag, "_valid"},   obs_valid, 0);
        check_eq({tag, "_respawn"}, obs_respawn, 0);
        check_eq({tag, "_count"},   obs_count, 0);
        check_eq({tag, "_size"},    obs_size, UPG_SIZE);
    endtask

    // Wait for the predicted spawn and check it; returns one cycle after the
    // spawn, with the upgrade in its active phase.
    task automatic do_spawn(input int p, input string tag, input bit verbose);
        int s_exp, xe, ye, got_ep;
        model_spawn(p, s_exp, xe, ye);
        got_ep = -1;
        while (ep <= s_exp + 10) begin
            if (obs_respawn) begin
                got_ep = ep;
                break;
            end
            tick();
        end
        exp_pulses++;
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        check_eq({tag, "_spawn_cycle"}, got_ep, s_exp);
        check_eq({tag, "_pulses"}, pulse_cnt, exp_pulses);
        check_eq({tag, "_x"}, obs_x, xe);
        check_eq({tag, "_y"}, obs_y, ye);
        check_eq({tag, "_valid_at_spawn"}, obs_valid, 1);
        tick();
        check_eq({tag, "_respawn_width"}, obs_respawn, 0);
        check_eq({tag, "_valid_active"}, obs_valid, 1);
        check_eq({tag, "_count"}, obs_count, exp_count);
        if (verbose)
            $display("spawn %s: cycle %0d pos (%0d,%0d) count %0d", tag, got_ep, obs_x, obs_y, obs_count);
    endtask

    // One-cycle pickup pulse; w returns the first cooldown cycle.
    task automatic pickup(input string tag, output int w);
        int hold_x, hold_y;
        hold_x    = int'(obs_x);
        hold_y    = int'(obs_y);
        collected = 1'b1;
        tick();
        collected = 1'b0;
        check_eq({tag, "_valid_drop"}, obs_valid, 0);
        check_eq({tag, "_hold_x"}, obs_x, hold_x);
        check_eq({tag, "_hold_y"}, obs_y, hold_y);
        w = ep;
    endtask

    initial begin
        int w;

        lf_tab[0] = SEED;
        for (int i = 1; i < LF_PERIOD; i++) begin
            int v;
            v = lf_tab[i - 1];
            lf_tab[i] = ((v << 1) & 'h3FF) | (((v >> 9) ^ (v >> 6)) & 1);
        end

        // Default instance: first spawn, collected ignored while waiting.
        sel = 1'b0; cfg_cool = 300; cfg_init = 60;
        apply_reset();
        check_reset("reset");
        while (ep < 10) tick();
        collected = 1'b1;
        repeat (3) tick();
        collected = 1'b0;
        do_spawn(cfg_init + 1, "first", 1'b1);
        check_eq("first_x_range", (obs_x >= XMIN) && (obs_x <= XMAX), 1);
        check_eq("first_y_range", (obs_y >= YMIN) && (obs_y <= YMAX), 1);
        check_eq("first_clear_b1", too_close(int'(obs_x), int'(obs_y), int'(b1x), int'(b1y)), 0);
        check_eq("first_clear_b2", too_close(int'(obs_x), int'(obs_y), int'(b2x), int'(b2y)), 0);

        // Pickup and full cooldown.
        pickup("pick1", w);
        do_spawn(w + cfg_cool + 1, "cooldown", 1'b1);

        // Random ball positions with a small ball.
        for (int k = 0; k < 3; k++) begin
            b1x = 10'($urandom_range(40, 600)); b1y = 10'($urandom_range(40, 440));
            b2x = 10'($urandom_range(40, 600)); b2y = 10'($urandom_range(40, 440));
            bsize = 10'($urandom_range(4, 40));
            pickup("pickr", w);
            do_spawn(w + cfg_cool + 1, "rand", 1'b1);
        end

        // Every candidate overlaps: fallback to the centre after all tries.
        b1x = 10'd320; b1y = 10'd240; b2x = 10'd320; b2y = 10'd240; bsize = 10'd300;
        pickup("pick_fb", w);
        do_spawn(w + cfg_cool + 1, "fallback", 1'b1);
        check_eq("fallback_x_const", obs_x, 320);
        check_eq("fallback_y_const", obs_y, 240);
        b1x = 10'd100; b1y = 10'd100; b2x = 10'd500; b2y = 10'd400; bsize = 10'd10;

        // Enable low for 50 frames during cooldown delays the spawn by 50.
        pickup("pick_en", w);
        repeat (20) tick();
        enable = 1'b0;
        repeat (50) tick();
        enable = 1'b1;
        do_spawn(w + cfg_cool + 1 + 50, "enable_pause", 1'b1);

        // Reset in the middle of a cooldown.
        pickup("pick_rc", w);
        repeat (100) tick();
        apply_reset();
        check_reset("reset_cool");
        do_spawn(cfg_init + 1, "after_reset_cool", 1'b1);

        // Reset while the candidate check is in progress.
        pickup("pick_rk", w);
        while (ep < w + cfg_cool + 1 + 2) tick();
        apply_reset();
        check_reset("reset_check");
        do_spawn(cfg_init + 1, "after_reset_check", 1'b1);

        // Zero-cooldown instance: 300 pickups, count saturates at 255.
        rst_main = 1'b1;
        sel = 1'b1; cfg_cool = 0; cfg_init = 3;
        apply_reset();
        check_reset("fast_reset");
        do_spawn(cfg_init + 1, "fast_first", 1'b1);
        for (int i = 1; i < 300; i++) begin
            pickup("fast_pick", w);
            do_spawn(w + cfg_cool + 1, "fast", (i % 50) == 0);
        end
        check_eq("saturated_count", obs_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upgrade_spawner.md
Name: upgrade_spawner

Overview:
Producer end of the upgrade pickup interface. It places an upgrade on the playfield and drives UpgradeX, UpgradeY and Upgrade_Size to the collector blocks. It waits for a collector to report pickup, hides the upgrade for a cooldown, then respawns it at an LFSR-chosen position that avoids both players. It runs once per frame in the game logic, on the same frame_clk as the player and upgrade modules.

Parameters:
COOLDOWN_FRAMES, 300, frames between pickup and the next spawn.
INITIAL_DELAY, 60, frames from reset to the first spawn.
UPGRADE_SIZE, 8, half-size driven on Upgrade_Size.
X_MIN, 40, lowest legal UpgradeX (inclusive).
X_MAX, 600, highest legal UpgradeX (inclusive).
Y_MIN, 40, lowest legal UpgradeY (inclusive).
Y_MAX, 440, highest legal UpgradeY (inclusive).
CLEARANCE, 16, extra gap kept between the upgrade and each ball.
LFSR_SEED, 10'h1A5, LFSR reset value; a value of 0 is replaced by 1.
MAX_TRIES, 8, rejected candidates allowed before the fallback position is used.

Ports:
frame_clk  in  1  clock.
Reset  in  1  synchronous, active-high reset.
enable  in  1  game running; when low, counters are frozen.
collected  in  1  level from the collector; 1 = upgrade picked up.
BallX, BallY  in  10  player 1 centre.
Ball2X, Ball2Y  in  10  player 2 centre.
Ball_Size  in  10  ball half-size.
UpgradeX, UpgradeY  out  10  upgrade centre.
Upgrade_Size  out  10  constant UPGRADE_SIZE.
upgrade_valid  out  1  upgrade is visible and collectable.
respawn  out  1  one-cycle pulse; collectors clear their collected flag on it.
spawn_count  out  8  number of spawns since reset, saturating at 255.

Behaviour:
- Reset is synchronous, active-high, sampled on posedge frame_clk. Reset values:
  - state = WAIT, wait counter = INITIAL_DELAY.
  - UpgradeX = UpgradeY = 0, upgrade_valid = 0, respawn = 0, spawn_count = 0.
  - lfsr = LFSR_SEED, tries = 0.
  - Reset overrides every other input, including mid-cooldown and mid-pick.
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1. It advances every cycle that Reset is low, regardless of enable. It never reaches 0.
- WAIT:
  - Counter decrements only when enable=1.
  - When counter==0 and enable=1, go to PICK_X.
  - upgrade_valid = 0 throughout.
- PICK_X: candidate X = lfsr. Reject if X < X_MIN or X > X_MAX. Go to PICK_Y.
- PICK_Y: candidate Y = lfsr (value one step later). Reject if Y < Y_MIN or Y > Y_MAX. Go to CHECK.
- CHECK:
  - Overlap with a ball exists when both |candX − BallX| and |candY − BallY| are ≤ Ball_Size + UPGRADE_SIZE + CLEARANCE. Same test for Ball2.
  - Differences and sums use 11-bit unsigned arithmetic, so there is no wrap.
  - A candidate that is out of range or overlapping is rejected. On reject, tries++. If tries < MAX_TRIES, go to PICK_X.
  - If tries == MAX_TRIES, use the fallback ((X_MIN+X_MAX)/2, (Y_MIN+Y_MAX)/2) without an overlap check.
  - On accept or fallback, latch UpgradeX/UpgradeY and go to SPAWN.
- SPAWN (1 cycle):
  - respawn = 1, upgrade_valid = 1.
  - spawn_count++, saturating at 255.
  - tries cleared. Go to ACTIVE.
- ACTIVE:
  - upgrade_valid = 1 and position held.
  - When collected=1, go to WAIT with counter = COOLDOWN_FRAMES; upgrade_valid drops on that edge.
  - collected is sampled from the first ACTIVE cycle. Collectors clear their flag on the respawn edge, so a stale flag is never seen.
  - enable=0 does not hide an active upgrade.
- respawn is high only in SPAWN. In every other state it is 0.
- UpgradeX/UpgradeY hold their last value after pickup. Only upgrade_valid governs visibility.
- COOLDOWN_FRAMES=0: the next spawn starts the cycle after pickup (WAIT is left immediately when enable=1).
- collected=1 in any state other than ACTIVE is ignored.

Decomposition:
- Shared game package holds:
  - the spawner state enum (WAIT, PICK_X, PICK_Y, CHECK, SPAWN, ACTIVE);
  - playfield bounds constants, shared with the ball modules;
  - the LFSR tap constant.
- Sub-module lfsr10 (seed parameter, step enable, 10-bit output). It is reused later for other random events.

Test Plan:
- Reset, enable=1, balls at (100,100) and (500,400) -> after 60 frames plus pick cycles: exactly one respawn pulse, upgrade_valid=1, X in [40,600], Y in [40,440], no overlap with either ball, spawn_count=1.
- In ACTIVE, pulse collected=1 for one cycle -> upgrade_valid=0 on the next edge; no respawn for 300 frames; respawn on a later cycle after that; spawn_count=2.
- Ball_Size=300 so every candidate overlaps -> exactly 8 rejections, then spawn at (320,240).
- enable=0 for 50 frames during cooldown -> spawn delayed by exactly 50 frames; LFSR sequence keeps advancing.
- Reset asserted mid-cooldown and mid-CHECK -> next cycle matches all reset values; first spawn is again INITIAL_DELAY frames later.
- 300 forced pickup/respawn cycles -> spawn_count saturates at 255; lfsr never 0.
